// File: rtl/fdct_pkg.sv
// Shared definitions for the streaming 8x8 forward DCT: configuration defaults,
// FSM state type, cosine constant table and JPEG zigzag read mapping.
package fdct_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_COEF_W    = 12;
  localparam int DEF_COEF_FRAC = 11;

  // Row-pass results: 16 bits with 3 fractional bits.
  localparam int MID_W = 16;
  // Accumulator width; products and 8-term sums fit without truncation.
  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    LOAD,
    ROW,
    COL,
    DRAIN
  } fdct_state_e;

  // C[u][x] = round(2048 * 0.5 * c(u) * cos((2x+1)*u*pi/16)); rows indexed by frequency u.
  localparam int COEF_TAB [8][8] = '{
    '{  724,   724,   724,   724,   724,   724,   724,   724},
    '{ 1004,   851,   569,   200,  -200,  -569,  -851, -1004},
    '{  946,   392,  -392,  -946,  -946,  -392,   392,   946},
    '{  851,  -200, -1004,  -569,   569,  1004,   200,  -851},
    '{  724,  -724,  -724,   724,   724,  -724,  -724,   724},
    '{  569, -1004,   200,   851,  -851,  -200,  1004,  -569},
    '{  392,  -946,   946,  -392,  -392,   946,  -946,   392},
    '{  200,  -569,   851, -1004,  1004,  -851,   569,  -200}
  };

  // Zigzag position k -> raster coefficient index (vertical_freq*8 + horizontal_freq).
  function automatic logic [5:0] zz_addr(input logic [5:0] k);
    localparam int ZZ_TAB [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    return 6'(ZZ_TAB[k]);
  endfunction

endpackage

// File: rtl/fdct_stream_dct8_1d.sv
// Combinational 8-point 1-D DCT shared by the row and column passes.
// col_pass selects the column rounding shift and output saturation range.
module dct8_1d
  import fdct_pkg::*;
#(
  parameter int IN_W      = MID_W,
  parameter int OUT_W     = MID_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int ROW_SHIFT = DEF_COEF_FRAC - 3,
  parameter int COL_SHIFT = DEF_COEF_FRAC + 3,
  parameter int ROW_SAT_W = MID_W,
  parameter int COL_SAT_W = DEF_DATA_W
) (
  input  logic                    col_pass,
  input  logic signed [IN_W-1:0]  x [8],
  output logic signed [OUT_W-1:0] y [8]
);

  localparam logic signed [ACC_W-1:0] ROW_RND = ACC_W'(1) << (ROW_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] COL_RND = ACC_W'(1) << (COL_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] ROW_MAX = (ACC_W'(1) << (ROW_SAT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] ROW_MIN = -(ACC_W'(1) << (ROW_SAT_W - 1));
  localparam logic signed [ACC_W-1:0] COL_MAX = (ACC_W'(1) << (COL_SAT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] COL_MIN = -(ACC_W'(1) << (COL_SAT_W - 1));

  logic signed [ACC_W-1:0]  acc [8];
  logic signed [ACC_W-1:0]  sh  [8];
  logic signed [ACC_W-1:0]  hi;
  logic signed [ACC_W-1:0]  lo;
  logic signed [COEF_W-1:0] c;

  // Multiply-accumulate each frequency, round-shift, then saturate.
  // NOTE: blocking assignments with defaults first keep this purely combinational (no latches).
  always_comb begin
    c  = '0;
    hi = col_pass ? COL_MAX : ROW_MAX;
    lo = col_pass ? COL_MIN : ROW_MIN;
    for (int u = 0; u < 8; u++) begin
      acc[u] = '0;
      for (int i = 0; i < 8; i++) begin
        c      = COEF_W'(COEF_TAB[u][i]);
        acc[u] = acc[u] + ACC_W'(c) * ACC_W'(x[i]);
      end
      if (col_pass) sh[u] = (acc[u] + COL_RND) >>> COL_SHIFT;
      else          sh[u] = (acc[u] + ROW_RND) >>> ROW_SHIFT;
      if (sh[u] > hi)      y[u] = OUT_W'(hi);
      else if (sh[u] < lo) y[u] = OUT_W'(lo);
      else                 y[u] = OUT_W'(sh[u]);
    end
  end

endmodule

// File: rtl/fdct_stream.sv
// Streaming 8x8 orthonormal forward DCT: load 64 samples, 8 row passes into a
// transpose buffer, 8 column passes into a coefficient buffer, then drain 64.
// Build option FDCT_ZIGZAG_EN: drain in JPEG zigzag order instead of raster order.
module fdct_stream
  import fdct_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);

  localparam int DP_W = (DATA_W > MID_W) ? DATA_W : MID_W;

  fdct_state_e state;
  logic [5:0]  in_cnt;
  logic [2:0]  pass_cnt;
  logic [5:0]  out_idx;

  logic signed [DATA_W-1:0] in_buf [64];
  logic signed [MID_W-1:0]  t_buf  [64];
  logic signed [DATA_W-1:0] c_buf  [64];

  logic signed [DP_W-1:0] dct_x [8];
  logic signed [DP_W-1:0] dct_y [8];
  logic                   col_pass;

  assign col_pass = (state == COL);

  // Feed the shared transform: a sample row in ROW, a transpose-buffer column in COL.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (state == COL) dct_x[i] = DP_W'(t_buf[{3'(i), pass_cnt}]);
      else              dct_x[i] = DP_W'(in_buf[{pass_cnt, 3'(i)}]);
    end
  end

  dct8_1d #(
    .IN_W      (DP_W),
    .OUT_W     (DP_W),
    .COEF_W    (COEF_W),
    .ROW_SHIFT (COEF_FRAC - 3),
    .COL_SHIFT (COEF_FRAC + 3),
    .ROW_SAT_W (MID_W),
    .COL_SAT_W (DATA_W)
  ) u_dct (
    .col_pass (col_pass),
    .x        (dct_x),
    .y        (dct_y)
  );

  // Drain read mapping; the build option changes only this address.
  function automatic logic [5:0] rd_addr(input logic [5:0] k);
`ifdef FDCT_ZIGZAG_EN
    return zz_addr(k);
`else
    return k;
`endif
  endfunction

  // Sample, transpose and coefficient buffers.
  // NOTE: storage arrays carry no reset; every entry is written before it is read in a block.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) in_buf[in_cnt] <= in_data;
    if (state == ROW) begin
      for (int u = 0; u < 8; u++) t_buf[{pass_cnt, 3'(u)}] <= MID_W'(dct_y[u]);
    end
    if (state == COL) begin
      for (int v = 0; v < 8; v++) c_buf[{3'(v), pass_cnt}] <= DATA_W'(dct_y[v]);
    end
  end

  // Block sequencer with registered handshake and output signals.
  // NOTE: all state here uses non-blocking assignments so every register updates off pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      in_cnt    <= '0;
      pass_cnt  <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            in_cnt <= in_cnt + 6'd1;
            if (in_cnt == 6'd63) begin
              in_ready <= 1'b0;
              pass_cnt <= '0;
              state    <= ROW;
            end
          end
        end
        ROW: begin
          pass_cnt <= pass_cnt + 3'd1;
          if (pass_cnt == 3'd7) state <= COL;
        end
        COL: begin
          pass_cnt <= pass_cnt + 3'd1;
          if (pass_cnt == 3'd7) begin
            out_idx <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            // First DRAIN cycle presents coefficient 0 of the read order.
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= c_buf[rd_addr(6'd0)];
          end else if (out_ready) begin
            if (out_idx == 6'd63) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              in_ready  <= 1'b1;
              state     <= LOAD;
            end else begin
              out_idx  <= out_idx + 6'd1;
              out_data <= c_buf[rd_addr(out_idx + 6'd1)];
              out_last <= (out_idx == 6'd62);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/fdct_stream.md
FDCT_STREAM -- requirements
Module: fdct_stream

Interface
REQ-001 Parameter DATA_W, 16, width of input samples and output coefficients.
REQ-002 Parameter COEF_W, 12, signed width of cosine constants.
REQ-003 Parameter COEF_FRAC, 11, fractional bits of cosine constants.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a valid sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  DATA_W  signed pixel sample, raster order within the 8x8 block; legal range -256..255.
REQ-009 out_valid  output  1  out_data holds a valid coefficient.
REQ-010 out_ready  input  1  downstream accepts the coefficient.
REQ-011 out_data  output  DATA_W  signed 2-D DCT coefficient.
REQ-012 out_last  output  1  high with the 64th coefficient of a block.

Function
REQ-013 The block SHALL compute the orthonormal 8x8 forward DCT, the inverse of the team's IDCT, processing one block at a time.
REQ-014 A transfer SHALL occur on a side when valid and ready are both high at a rising edge; data SHALL be held stable by the sender while valid is high and ready is low.
REQ-015 The FSM SHALL have states LOAD, ROW, COL and DRAIN; reset state LOAD.
REQ-016 LOAD: in_ready=1; accepted samples are written to buffer index 0..63; after the 64th transfer, go to ROW.
REQ-017 ROW: 8 cycles, one row per cycle through the 1-D transform, results into the transpose buffer; then COL.
REQ-018 COL: 8 cycles, one column per cycle; then DRAIN.
REQ-019 DRAIN: out_valid=1; emit 64 coefficients, advancing only on transfer; out_last on the 64th; after it, return to LOAD.
REQ-020 in_ready SHALL be 0 outside LOAD, and out_valid SHALL be 0 outside DRAIN; there is no overlap between blocks.
REQ-021 The first out_valid SHALL rise exactly 17 cycles after the edge that accepts the 64th sample.
REQ-022 Row pass: y = (sum C[u][x]*v[x] + 2^(COEF_FRAC-4)) >>> (COEF_FRAC-3); results are saturated to 16 bits with 3 fractional bits.
REQ-023 Column pass: y = (sum C[u][x]*v[x] + 2^(COEF_FRAC+2)) >>> (COEF_FRAC+3); results are saturated to DATA_W.
REQ-024 C[u][x] = round(2^COEF_FRAC * 0.5 * c(u) * cos((2x+1)u*pi/16)), where c(0)=1/sqrt2 and c(u>0)=1; C[0][x]=724.
REQ-025 Accumulation SHALL use at least 32 bits with no intermediate truncation.
REQ-026 An out_ready deassertion in DRAIN SHALL hold out_data, out_last and the index unchanged.

Reset
REQ-027 rst SHALL force LOAD with all counters at 0, and set in_ready=1, out_valid=0, out_last=0, out_data=0.
REQ-028 A reset mid-block, in any state, SHALL discard the partial block; the next 64 accepted samples form a new block.
REQ-029 Buffer contents SHALL need no reset.

Configuration
REQ-030 With FDCT_ZIGZAG_EN defined, DRAIN SHALL emit coefficients in JPEG zigzag order (raster index 0,1,8,16,9,2,...,63).
REQ-031 Without FDCT_ZIGZAG_EN, DRAIN SHALL emit coefficients in raster order (u-major, index 0..63).
REQ-032 The macro SHALL alter only the read-address mapping; latency and handshakes are identical in both builds.

Structure
REQ-033 Package fdct_pkg SHALL hold the 8x8 constant table C, the 64-entry zigzag table, the state enum type, and the DATA_W/COEF_W defaults.
REQ-034 The 1-D transform SHALL be sub-module dct8_1d: 8 signed inputs, 8 outputs, combinational, with the shift amount as a parameter; it is instantiated once and shared by ROW and COL.

Verification
REQ-035 Constant input 10 for all 64 samples -> coefficient 0 = 80; coefficients 1..63 = 0; out_last only on the 64th coefficient.
REQ-036 Constant input -128 -> coefficient 0 = -1024; all others 0; first out_valid 17 cycles after the 64th input.
REQ-037 in[0]=64, others 0 -> raster coefficient 0 = 8.
REQ-038 out_ready toggled 1/0 each cycle in DRAIN -> same 64 values as with out_ready held high; no duplicates or losses; in_ready stays 0 until after out_last.
REQ-039 rst pulsed after 30 inputs, then a constant-10 block -> output coefficient 0 = 80, with no residue from the aborted block.
REQ-040 Random block run in both builds -> zigzag output k equals raster output ZZ[k] for every k (e.g. k=2 equals raster index 8).
